// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for a cascaded chain of BCD counter digits: start/pause/
// clear/preload, tick gating, terminal-value compare with done and wrap strobes.
module bcd_count_ctrl #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] target,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic [1:0]          state,
  output logic                running,
  output logic                done,
  output logic                wrap
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e         state_q;
  logic [W-1:0]   count_q;
  logic           running_q;
  logic           done_q;
  logic           wrap_q;

  logic [W-1:0]   inc_d;
  logic           carry_d;
  logic [W-1:0]   load_d;
  logic           target_hit;

  // Ripple BCD increment; carry out is set only when every digit was 9.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         c;
    logic [3:0]   dig;
    res = '0;
    c   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig = v[4*i +: 4];
      if (c && dig == 4'd9) begin
        res[4*i +: 4] = 4'd0;
      end else if (c) begin
        res[4*i +: 4] = dig + 4'd1;
        c = 1'b0;
      end else begin
        res[4*i +: 4] = dig;
      end
    end
    return {c, res};
  endfunction

  // NOTE: combinational logic uses blocking '=' with a default first so no latch is
  // inferred; the register block below uses non-blocking '<=' only.
  always_comb begin
    {carry_d, inc_d} = bcd_inc(count_q);
    load_d     = '0;
    target_hit = (inc_d == target);
    for (int i = 0; i < DIGITS; i++) begin
      load_d[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
      if (target[4*i +: 4] > 4'd9) target_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clear) begin
        state_q   <= S_IDLE;
        count_q   <= '0;
        running_q <= 1'b0;
      end else if (load && (state_q == S_IDLE || state_q == S_PAUSE)) begin
        count_q <= load_d;
      end else begin
        // A load in RUN/DONE is treated as absent, so lower-priority commands apply.
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (stop) begin
              state_q   <= S_PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              count_q <= inc_d;
              wrap_q  <= carry_d;
              if (target_hit) begin
                state_q   <= S_DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end
          end
          S_PAUSE: begin
            if (start && !stop) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          S_DONE: begin
            if (start) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign count   = count_q;
  assign state   = state_q;
  assign running = running_q;
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed self-checking bench for bcd_count_ctrl with DIGITS=2.
module tb_bcd_count_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, clear, load, tick;
  logic [7:0] load_val, target;
  logic [7:0] count;
  logic [1:0] state;
  logic       running, done, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_count_ctrl #(.DIGITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .target(target), .tick(tick),
    .count(count), .state(state), .running(running), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge before sampling.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; tick = 1'b0;
    load_val = 8'h00; target = 8'h99;
    step(2);
    check("rst_count", count, 8'h00);
    check("rst_state", state, 2'b00);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wrap", wrap, 1'b0);

    // start, 12 ticks
    rst_n = 1'b1;
    pulse_start();
    check("start_state", state, 2'b01);
    check("start_running", running, 1'b1);
    tick = 1'b1; step(12); tick = 1'b0;
    check("t12_count", count, 8'h12);
    check("t12_state", state, 2'b01);
    check("t12_done", done, 1'b0);
    check("t12_wrap", wrap, 1'b0);

    // preload 0x98 and roll over
    target = 8'h50;
    clear = 1'b1; step(); clear = 1'b0;
    check("clr_state", state, 2'b00);
    check("clr_count", count, 8'h00);
    load = 1'b1; load_val = 8'h98; step(); load = 1'b0;
    check("ld98_count", count, 8'h98);
    check("ld98_state", state, 2'b00);
    pulse_start();
    tick = 1'b1; step();
    check("inc99_count", count, 8'h99);
    check("inc99_wrap", wrap, 1'b0);
    step();
    check("wrap_count", count, 8'h00);
    check("wrap_pulse", wrap, 1'b1);
    check("wrap_state", state, 2'b01);
    tick = 1'b0; step();
    check("wrap_clear", wrap, 1'b0);

    // terminal at 0x05
    clear = 1'b1; step(); clear = 1'b0;
    target = 8'h05;
    pulse_start();
    tick = 1'b1; step(4);
    check("t4_state", state, 2'b01);
    step();
    check("term_count", count, 8'h05);
    check("term_state", state, 2'b11);
    check("term_done", done, 1'b1);
    check("term_running", running, 1'b0);
    step(3);
    check("hold_count", count, 8'h05);
    check("hold_done", done, 1'b0);
    check("hold_state", state, 2'b11);
    tick = 1'b0;

    // pause at 0x37 with stop+tick, resume
    clear = 1'b1; step(); clear = 1'b0;
    target = 8'h99;
    load = 1'b1; load_val = 8'h36; step(); load = 1'b0;
    pulse_start();
    tick = 1'b1; step(); tick = 1'b0;
    check("at37_count", count, 8'h37);
    stop = 1'b1; tick = 1'b1; step(); stop = 1'b0; tick = 1'b0;
    check("pause_state", state, 2'b10);
    check("pause_count", count, 8'h37);
    check("pause_running", running, 1'b0);
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    check("stop_wins", state, 2'b10);
    pulse_start();
    check("resume_state", state, 2'b01);
    check("resume_count", count, 8'h37);
    tick = 1'b1; step(); tick = 1'b0;
    check("resume_inc", count, 8'h38);

    // load sanitizing in PAUSE, ignored in RUN
    stop = 1'b1; step(); stop = 1'b0;
    load = 1'b1; load_val = 8'hA3; step(); load = 1'b0;
    check("ldA3_count", count, 8'h03);
    check("ldA3_state", state, 2'b10);
    pulse_start();
    load = 1'b1; load_val = 8'h55; step(); load = 1'b0;
    check("ldrun_count", count, 8'h03);
    check("ldrun_state", state, 2'b01);

    // clear+load+tick in RUN
    clear = 1'b1; load = 1'b1; load_val = 8'h44; tick = 1'b1; step();
    clear = 1'b0; load = 1'b0; tick = 1'b0;
    check("cmb_state", state, 2'b00);
    check("cmb_count", count, 8'h00);

    // wrap and terminal together (target 0x00)
    load = 1'b1; load_val = 8'h99; step(); load = 1'b0;
    target = 8'h00;
    pulse_start();
    tick = 1'b1; step(); tick = 1'b0;
    check("wd_count", count, 8'h00);
    check("wd_wrap", wrap, 1'b1);
    check("wd_done", done, 1'b1);
    check("wd_state", state, 2'b11);

    // target with invalid digit never matches
    target = 8'h0A;
    pulse_start();
    tick = 1'b1; step(10); tick = 1'b0;
    check("badtgt_count", count, 8'h10);
    check("badtgt_state", state, 2'b01);

    // reset mid-RUN
    tick = 1'b1; step(); rst_n = 1'b0; step(); tick = 1'b0;
    check("mrst_count", count, 8'h00);
    check("mrst_state", state, 2'b00);
    check("mrst_running", running, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_wrap", wrap, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
